mult_err_sweep_ctrl: RTL and testbench

MULT_ERR_SWEEP_CTRL -- requirements
Module: mult_err_sweep_ctrl

---
 rtl/mult_err_sweep_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mult_err_sweep_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_err_sweep_ctrl.sv
// Exhaustive 8x8 multiplier error sweep controller.
// Issues all 65536 operand pairs and tracks error-distance statistics of res_in.
module mult_err_sweep_ctrl #(
    parameter int LAT   = 1,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [7:0]       op_a,
    output logic [7:0]       op_b,
    output logic             op_vld,
    input  logic [15:0]      res_in,
    output logic             busy,
    output logic             done,
    output logic [16:0]      err_cnt,
    output logic [15:0]      max_ed,
    output logic [7:0]       max_a,
    output logic [7:0]       max_b,
    output logic [ACC_W-1:0] sum_ed
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int D = (LAT > 0) ? LAT : 1;
    localparam logic [2:0] DRAIN_INIT = 3'((LAT > 0) ? LAT - 1 : 0);

    state_t      state;
    logic [15:0] k;
    logic [2:0]  dcnt;
    logic        clr;
    logic        flush;

    assign op_a  = k[15:8];
    assign op_b  = k[7:0];
    assign clr   = (state == IDLE) && start;
    assign flush = ((state == RUN) || (state == DRAIN)) && abort;

    // k doubles as the operand register; it rests at zero outside RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            op_vld <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dcnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        k      <= '0;
                        op_vld <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state  <= IDLE;
                        k      <= '0;
                        op_vld <= 1'b0;
                        busy   <= 1'b0;
                    end else if (k == 16'hFFFF) begin
                        k      <= '0;
                        op_vld <= 1'b0;
                        if (LAT == 0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                            dcnt  <= DRAIN_INIT;
                        end
                    end else begin
                        k <= k + 16'd1;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (dcnt == 3'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [D-1:0] dv;
    logic [7:0]   da [D];
    logic [7:0]   db [D];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dv <= '0;
        end else begin
            dv[0] <= op_vld;
            for (int i = 1; i < D; i++) dv[i] <= dv[i-1];
        end
    end

    always_ff @(posedge clk) begin
        da[0] <= op_a;
        db[0] <= op_b;
        for (int i = 1; i < D; i++) begin
            da[i] <= da[i-1];
            db[i] <= db[i-1];
        end
    end

    logic       p_v;
    logic [7:0] p_a;
    logic [7:0] p_b;

    // LAT=0 compares the pair issued in the same cycle
    generate
        if (LAT == 0) begin : g_nodly
            assign p_v = op_vld;
            assign p_a = op_a;
            assign p_b = op_b;
        end else begin : g_dly
            assign p_v = dv[LAT-1];
            assign p_a = da[LAT-1];
            assign p_b = db[LAT-1];
        end
    endgenerate

    logic [15:0] exact;
    logic [15:0] ed;

    assign exact = 16'(p_a) * 16'(p_b);
    assign ed    = (exact >= res_in) ? exact - res_in : res_in - exact;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_cnt <= '0;
            max_ed  <= '0;
            max_a   <= '0;
            max_b   <= '0;
            sum_ed  <= '0;
        end else if (p_v) begin
            if (ed != 16'd0) err_cnt <= err_cnt + 17'd1;
            sum_ed <= sum_ed + ACC_W'(ed);
            if (ed > max_ed) begin
                max_ed <= ed;
                max_a  <= p_a;
                max_b  <= p_b;
            end
        end
    end

endmodule

// File: tb/tb_mult_err_sweep_ctrl.sv
// Bench for mult_err_sweep_ctrl: six instances (LAT 0..4, several fault models)
// share one full sweep; abort and mid-sweep reset are exercised first.
module tb_mult_err_sweep_ctrl;

    localparam int N = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  op_a [N];
    logic [7:0]  op_b [N];
    logic        op_vld [N];
    logic [15:0] res_in [N];
    logic        busy [N];
    logic        done [N];
    logic [16:0] err_cnt [N];
    logic [15:0] max_ed [N];
    logic [7:0]  max_a [N];
    logic [7:0]  max_b [N];
    logic [31:0] sum_ed [N];

    logic [15:0] rnd_tab [65536];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int g);
        case (g)
            0, 1:    return 1;
            2:       return 2;
            3:       return 0;
            4:       return 4;
            default: return 3;
        endcase
    endfunction

    // 0 exact, 1 stuck at zero, 2 single fault at (3,5), 3 random table
    function automatic int mode_of(int g);
        case (g)
            1:       return 1;
            2:       return 2;
            5:       return 3;
            default: return 0;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : gi
        localparam int L = lat_of(g);
        localparam int M = mode_of(g);
        logic [31:0] ha, hb;
        logic [39:0] fa, fb;
        logic [7:0]  pa, pb;
        logic [15:0] p;
        always @(posedge clk) begin
            ha <= {ha[23:0], op_a[g]};
            hb <= {hb[23:0], op_b[g]};
        end
        assign fa = {ha, op_a[g]};
        assign fb = {hb, op_b[g]};
        assign pa = fa[8*L+7 -: 8];
        assign pb = fb[8*L+7 -: 8];
        assign p  = 16'(pa) * 16'(pb);
        assign res_in[g] = (M == 1) ? 16'd0 :
                           (M == 2 && pa == 8'd3 && pb == 8'd5) ? p + 16'd1 :
                           (M == 3) ? rnd_tab[{pa, pb}] : p;

        mult_err_sweep_ctrl #(.LAT(L), .ACC_W(32)) dut (
            .clk(clk), .rst(rst), .start(start), .abort(abort),
            .op_a(op_a[g]), .op_b(op_b[g]), .op_vld(op_vld[g]),
            .res_in(res_in[g]), .busy(busy[g]), .done(done[g]),
            .err_cnt(err_cnt[g]), .max_ed(max_ed[g]),
            .max_a(max_a[g]), .max_b(max_b[g]), .sum_ed(sum_ed[g])
        );
    end

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(int i, string tag);
        chk($sformatf("%s%0d_op_a", tag, i), op_a[i], 0);
        chk($sformatf("%s%0d_op_b", tag, i), op_b[i], 0);
        chk($sformatf("%s%0d_op_vld", tag, i), op_vld[i], 0);
        chk($sformatf("%s%0d_busy", tag, i), busy[i], 0);
        chk($sformatf("%s%0d_done", tag, i), done[i], 0);
        chk($sformatf("%s%0d_err_cnt", tag, i), err_cnt[i], 0);
        chk($sformatf("%s%0d_max_ed", tag, i), max_ed[i], 0);
        chk($sformatf("%s%0d_max_a", tag, i), max_a[i], 0);
        chk($sformatf("%s%0d_max_b", tag, i), max_b[i], 0);
        chk($sformatf("%s%0d_sum_ed", tag, i), sum_ed[i], 0);
    endtask

    // Timeline checker for the full sweep, counted per instance
    bit mon_on = 1'b0;
    int mon_c0 = 0;
    int seq_bad [N] = '{default: 0};
    int dn_cnt [N] = '{default: 0};

    always @(negedge clk) begin
        if (mon_on) begin
            int rel;
            int l;
            logic ev, eb, edn;
            logic [15:0] ek;
            rel = cyc - mon_c0;
            for (int i = 0; i < N; i++) begin
                l   = lat_of(i);
                ev  = (rel >= 1) && (rel <= 65536);
                eb  = (rel >= 1) && (rel <= 65536 + l);
                edn = (rel == 65537 + l);
                ek  = ev ? 16'(rel - 1) : 16'd0;
                if (op_vld[i] !== ev || busy[i] !== eb || done[i] !== edn ||
                    op_a[i] !== ek[15:8] || op_b[i] !== ek[7:0])
                    seq_bad[i]++;
                if (done[i]) dn_cnt[i]++;
            end
        end
    end

    typedef struct {
        int     inst;
        int     err;
        int     mx;
        int     ma;
        int     mb;
        longint sum;
    } exp_t;

    exp_t tbl [N];

    initial begin
        int c0, c1, c2, nd;
        int a, b, pr, r, e;
        int m_err, m_mx, m_ma, m_mb;
        longint m_sum;

        for (int kk = 0; kk < 65536; kk++) begin
            int sel, pp;
            pp  = (kk >> 8) * (kk & 255);
            sel = int'($urandom_range(0, 9));
            if (sel <= 6) rnd_tab[kk] = 16'(pp);
            else if (sel == 7) rnd_tab[kk] = 16'(pp + int'($urandom_range(1, 3)));
            else if (sel == 8) rnd_tab[kk] = 16'((pp >= 3) ? pp - 2 : pp);
            else rnd_tab[kk] = 16'($urandom);
        end

        m_err = 0; m_mx = 0; m_ma = 0; m_mb = 0; m_sum = 0;
        for (int kk = 0; kk < 65536; kk++) begin
            a  = kk / 256;
            b  = kk % 256;
            pr = a * b;
            r  = int'(rnd_tab[kk]);
            e  = (pr > r) ? pr - r : r - pr;
            if (e != 0) m_err++;
            m_sum += e;
            if (e > m_mx) begin
                m_mx = e; m_ma = a; m_mb = b;
            end
        end

        tbl[0] = '{0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 65025, 65025, 255, 255, 64'd1065369600};
        tbl[2] = '{2, 1, 1, 3, 5, 1};
        tbl[3] = '{3, 0, 0, 0, 0, 0};
        tbl[4] = '{4, 0, 0, 0, 0, 0};
        tbl[5] = '{5, m_err, m_mx, m_ma, m_mb, m_sum & 64'hFFFF_FFFF};

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) chk_reset(i, "rst");

        // abort during RUN
        step();
        start = 1'b1;
        c0 = cyc;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) chk($sformatf("run%0d_busy", i), busy[i], 1);
        while (cyc < c0 + 1000) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("abort%0d_busy", i), busy[i], 0);
            chk($sformatf("abort%0d_vld", i), op_vld[i], 0);
            chk($sformatf("abort%0d_ops", i), {op_a[i], op_b[i]}, 0);
        end
        nd = 0;
        repeat (12) begin
            for (int i = 0; i < N; i++) if (done[i]) nd++;
            step();
        end
        chk("abort_no_done", nd, 0);

        // start and abort together in IDLE, then reset mid-sweep
        start = 1'b1;
        abort = 1'b1;
        c1 = cyc;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_wins_busy", busy[0], 1);
        chk("start_wins_vld", op_vld[0], 1);
        while (cyc < c1 + 3000) step();
        chk("pre_rst_err_nonzero", err_cnt[1] != 0, 1);
        rst = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < N; i++) chk_reset(i, "midrst");
        step();
        chk("post_rst_idle", busy[0], 0);

        // full sweep on all instances with a stray start mid-RUN
        step();
        start = 1'b1;
        c2 = cyc;
        mon_c0 = c2;
        mon_on = 1'b1;
        step();
        start = 1'b0;
        while (cyc < c2 + 500) step();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < c2 + 65545) step();
        mon_on = 1'b0;

        for (int r2 = 0; r2 < N; r2++) begin
            int i;
            i = tbl[r2].inst;
            chk($sformatf("sw%0d_err_cnt", i), err_cnt[i], tbl[r2].err);
            chk($sformatf("sw%0d_max_ed", i), max_ed[i], tbl[r2].mx);
            chk($sformatf("sw%0d_max_a", i), max_a[i], tbl[r2].ma);
            chk($sformatf("sw%0d_max_b", i), max_b[i], tbl[r2].mb);
            chk($sformatf("sw%0d_sum_ed", i), sum_ed[i], tbl[r2].sum);
            chk($sformatf("sw%0d_timeline", i), seq_bad[i], 0);
            chk($sformatf("sw%0d_done_pulses", i), dn_cnt[i], 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
